// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout -- parametrised VGA timing generator and framebuffer scanout.
//
// Counts pixels (h) and lines (v), issues linear framebuffer reads for the
// visible area, absorbs RD_LAT cycles of memory latency and drives the VGA
// pins with sync, valid and RGB realigned to the pixel data.
// Optional 2x mode reads each source pixel twice per line and each source
// line twice per frame. The mode is chosen once per frame.
//
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   en                scanout enable (low parks the raster at (0,0))
//   scale2x           pixel-doubling request, latched at frame start
//   fb_rd, fb_addr    framebuffer read strobe and word address
//   fb_data           {R,G,B} returned RD_LAT cycles after fb_rd
//   hsync, vsync      sync pins, SYNC_POL when asserted
//   valid             active-video indicator
//   vga_r/g/b         pixel colour, zero outside active video
//   frame_start       one-cycle pulse with the first active pixel
module vga_fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              scale2x,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [23:0]       fb_data,
    output logic              hsync,
    output logic              vsync,
    output logic              valid,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int STAGES  = RD_LAT + 2;
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
    } flags_t;

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    logic              mode;
    logic [ADDR_W-1:0] line_base;
    logic              h_last, v_last;
    logic [ADDR_W-1:0] pix_off, base_inc, addr_t;
    flags_t            flg_t;
    flags_t            flg_pipe [STAGES:1];
    logic [23:0]       rgb_q;

    assign h_last = (int'(h) == H_TOTAL - 1);
    assign v_last = (int'(v) == V_TOTAL - 1);

    // Linear address without a multiplier: line_base accumulates one line
    // stride per (source) line, the pixel offset is added on top.
    assign pix_off  = mode ? ADDR_W'(h >> 1) : ADDR_W'(h);
    assign base_inc = mode ? ADDR_W'(H_ACTIVE / 2) : ADDR_W'(H_ACTIVE);
    assign addr_t   = line_base + pix_off;

    // Timing flags for the current counter state; en low injects idle slots.
    always_comb begin
        flg_t     = '0;
        flg_t.act = en && (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
        flg_t.hs  = en && (int'(h) >= H_ACTIVE + H_FP)
                       && (int'(h) <  H_ACTIVE + H_FP + H_SYNC);
        flg_t.vs  = en && (int'(v) >= V_ACTIVE + V_FP)
                       && (int'(v) <  V_ACTIVE + V_FP + V_SYNC);
        flg_t.fs  = en && (h == '0) && (v == '0);
    end

    // Raster counters, line base and frame mode. While en is low the raster
    // is re-forced to (0,0) every cycle, so each of those cycles is a frame
    // boundary and the mode keeps tracking scale2x until scanout starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            h         <= '0;
            v         <= '0;
            mode      <= 1'b0;
            line_base <= '0;
        end else if (!en) begin
            h         <= '0;
            v         <= '0;
            mode      <= scale2x;
            line_base <= '0;
        end else if (h_last) begin
            h <= '0;
            if (v_last) begin
                v         <= '0;
                line_base <= '0;
                mode      <= scale2x;
            end else begin
                v <= v + 1'b1;
                // 2x mode repeats each source line: advance only after odd lines.
                if ((int'(v) < V_ACTIVE) && (!mode || v[0]))
                    line_base <= line_base + base_inc;
            end
        end else begin
            h <= h + 1'b1;
        end
    end

    // Read request stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_rd   <= 1'b0;
            fb_addr <= '0;
        end else begin
            fb_rd <= flg_t.act;
            if (flg_t.act)
                fb_addr <= addr_t;
        end
    end

    // Flag pipe: stage k holds the flags of the counter state k cycles ago.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++)
                flg_pipe[k] <= '0;
        end else begin
            flg_pipe[1] <= flg_t;
            for (int k = 2; k <= STAGES; k++)
                flg_pipe[k] <= flg_pipe[k-1];
        end
    end

    // fb_data is valid in the same cycle as stage STAGES-1; register it out
    // alongside the last flag stage so colour and sync stay aligned.
    always_ff @(posedge clk) begin
        if (reset)
            rgb_q <= '0;
        else
            rgb_q <= flg_pipe[STAGES-1].act ? fb_data : 24'h0;
    end

    assign valid       = flg_pipe[STAGES].act;
    assign frame_start = flg_pipe[STAGES].fs;
    assign hsync       = flg_pipe[STAGES].hs ? SYNC_ACT : ~SYNC_ACT;
    assign vsync       = flg_pipe[STAGES].vs ? SYNC_ACT : ~SYNC_ACT;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: two instances (RD_LAT=1 and RD_LAT=3) on a small
// raster, each fed by a latency-matched framebuffer model returning a value
// derived from the address. A frame-level reference model predicts every
// output on every cycle; directed probes and timing measurements cover the
// addressing and sync corner cases.
module tb_vga_fb_scanout;
    localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
    localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset, en, scale2x;
    logic fb_rd1, fb_rd3;
    logic [AW-1:0] fb_addr1, fb_addr3;
    logic [23:0] fb_data1, fb_data3;
    logic hsync1, vsync1, valid1, fs1, hsync3, vsync3, valid3, fs3;
    logic [7:0] r1, g1, b1, r3, g3, b3;

    always #5 clk = ~clk;

    vga_fb_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0),
        .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .scale2x(scale2x),
        .fb_rd(fb_rd1), .fb_addr(fb_addr1), .fb_data(fb_data1),
        .hsync(hsync1), .vsync(vsync1), .valid(valid1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1));

    vga_fb_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(0),
        .ADDR_W(AW), .RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .scale2x(scale2x),
        .fb_rd(fb_rd3), .fb_addr(fb_addr3), .fb_data(fb_data3),
        .hsync(hsync3), .vsync(vsync3), .valid(valid3),
        .vga_r(r3), .vga_g(g3), .vga_b(b3), .frame_start(fs3));

    function automatic logic [23:0] mem_fn(input logic [AW-1:0] a);
        return {8'h5A, a, ~a};
    endfunction

    // Framebuffer models: data for a read issued in cycle c is visible in c+RD_LAT.
    always @(posedge clk) fb_data1 <= fb_rd1 ? mem_fn(fb_addr1) : 24'hBADBAD;
    logic [23:0] mq3 [0:2];
    always @(posedge clk) begin
        mq3[0] <= fb_rd3 ? mem_fn(fb_addr3) : 24'hBADBAD;
        mq3[1] <= mq3[0];
        mq3[2] <= mq3[1];
    end
    assign fb_data3 = mq3[2];

    // Reference model: per-cycle record of what the raster is showing.
    typedef struct { bit act, hs, vs, fs, rst; int addr; } rec_t;
    rec_t recs[$];
    int  cyc = 0;
    int  mh = 0, mv = 0, ea = 0;
    bit  mmode = 0;
    int  n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    endtask

    // Expected {fb_rd, fb_addr, hsync, vsync, valid, frame_start, rgb} now.
    function automatic logic [36:0] exp_vec(input int lat);
        bit act = 0, hs = 0, vs = 0, fs = 0, rdv;
        int a = 0;
        if (cyc - lat >= 0) begin
            act = recs[cyc-lat].act; hs = recs[cyc-lat].hs;
            vs = recs[cyc-lat].vs; fs = recs[cyc-lat].fs; a = recs[cyc-lat].addr;
            for (int k = cyc - lat; k < cyc; k++)
                if (recs[k].rst) begin act = 0; hs = 0; vs = 0; fs = 0; end
        end
        rdv = recs[cyc-1].act;
        return {rdv, 8'(ea), ~hs, ~vs, act, fs, act ? mem_fn(8'(a)) : 24'h0};
    endfunction

    // Advance one clock with the currently driven inputs, then check both DUTs.
    task automatic cycle();
        rec_t r;
        bit on;
        on     = !reset && en;
        r.rst  = reset;
        r.act  = on && mh < HA && mv < VA;
        r.hs   = on && mh >= HA + HFP && mh < HA + HFP + HS;
        r.vs   = on && mv >= VA + VFP && mv < VA + VFP + VS;
        r.fs   = on && mh == 0 && mv == 0;
        r.addr = (mmode ? (mv / 2) * (HA / 2) + mh / 2 : mv * HA + mh) % (1 << AW);
        recs.push_back(r);
        if (reset) ea = 0;
        else if (r.act) ea = r.addr;
        if (reset) begin mh = 0; mv = 0; mmode = 0; end
        else if (!en) begin mh = 0; mv = 0; mmode = scale2x; end
        else if (mh == HT - 1) begin
            mh = 0;
            if (mv == VT - 1) begin mv = 0; mmode = scale2x; end
            else mv++;
        end else mh++;
        @(negedge clk);
        cyc++;
        check("model_lat1", 64'({fb_rd1, fb_addr1, hsync1, vsync1, valid1, fs1, r1, g1, b1}),
              64'(exp_vec(3)));
        check("model_lat3", 64'({fb_rd3, fb_addr3, hsync3, vsync3, valid3, fs3, r3, g3, b3}),
              64'(exp_vec(5)));
    endtask

    typedef struct { bit mode, tog; int h, v; int exp_addr; } probe_t;
    probe_t probes[$];

    initial begin
        int fs_t[$];
        int hs_run, hs_min, hs_max, first_hs;
        int vs_run, vs_min, vs_max, first_vs;
        int va_run, va_min, va_max;

        // Address probes: {mode, toggle scale2x right after start, h, v, expected addr}.
        probes.push_back('{0, 0, 0, 1, 8});
        probes.push_back('{0, 0, 7, 5, 47});
        probes.push_back('{0, 0, 3, 2, 19});
        probes.push_back('{0, 1, 5, 3, 29});
        probes.push_back('{1, 0, 0, 0, 0});
        probes.push_back('{1, 0, 1, 0, 0});
        probes.push_back('{1, 0, 0, 1, 0});
        probes.push_back('{1, 0, 1, 1, 0});
        probes.push_back('{1, 1, 2, 2, 5});
        probes.push_back('{1, 1, 7, 5, 11});

        // Reset with en high for 3 cycles.
        reset = 1; en = 1; scale2x = 0;
        repeat (3) cycle();
        reset = 0;
        check("rst_fb_rd", 64'(fb_rd1), 64'(0));
        check("rst_fb_addr", 64'(fb_addr1), 64'(0));
        check("rst_valid_fs", 64'({valid1, fs1, valid3, fs3}), 64'(0));
        check("rst_sync", 64'({hsync1, vsync1, hsync3, vsync3}), 64'hF);
        check("rst_rgb", 64'({r1, g1, b1, r3, g3, b3}), 64'(0));
        cycle();
        check("post_rst_fb_rd", 64'(fb_rd1), 64'(1));

        foreach (probes[i]) begin
            reset = 1; en = 0; cycle(); cycle();
            reset = 0; scale2x = probes[i].mode; cycle();
            en = 1;
            if (probes[i].tog) scale2x = ~probes[i].mode;
            repeat (probes[i].v * HT + probes[i].h) cycle();
            cycle();
            check($sformatf("probe%0d_addr", i), 64'({fb_rd1, fb_addr1}),
                  64'({1'b1, 8'(probes[i].exp_addr)}));
        end

        // Sync / valid / frame timing over two frames.
        reset = 1; en = 0; scale2x = 0; cycle();
        reset = 0; en = 1;
        hs_run = 0; hs_min = 9999; hs_max = 0; first_hs = -1;
        vs_run = 0; vs_min = 9999; vs_max = 0; first_vs = -1;
        va_run = 0; va_min = 9999; va_max = 0;
        for (int i = 0; i < 2 * HT * VT + 20; i++) begin
            cycle();
            if (fs1) fs_t.push_back(cyc);
            if (!hsync1) begin
                if (hs_run == 0 && first_hs < 0 && fs_t.size() > 0) first_hs = cyc;
                hs_run++;
            end else if (hs_run > 0) begin
                hs_min = (hs_run < hs_min) ? hs_run : hs_min;
                hs_max = (hs_run > hs_max) ? hs_run : hs_max;
                hs_run = 0;
            end
            if (!vsync1) begin
                if (vs_run == 0 && first_vs < 0 && fs_t.size() > 0) first_vs = cyc;
                vs_run++;
            end else if (vs_run > 0) begin
                vs_min = (vs_run < vs_min) ? vs_run : vs_min;
                vs_max = (vs_run > vs_max) ? vs_run : vs_max;
                vs_run = 0;
            end
            if (valid1) va_run++;
            else if (va_run > 0) begin
                va_min = (va_run < va_min) ? va_run : va_min;
                va_max = (va_run > va_max) ? va_run : va_max;
                va_run = 0;
            end
        end
        check("frame_count", 64'(fs_t.size()), 64'(3));
        if (fs_t.size() >= 2) begin
            check("frame_period", 64'(fs_t[1] - fs_t[0]), 64'(HT * VT));
            check("hsync_offset", 64'(first_hs - fs_t[0]), 64'(HA + HFP));
            check("vsync_offset", 64'(first_vs - fs_t[0]), 64'((VA + VFP) * HT));
        end
        check("hsync_width", 64'({32'(hs_min), 32'(hs_max)}), 64'({32'(HS), 32'(HS)}));
        check("vsync_width", 64'({32'(vs_min), 32'(vs_max)}), 64'({32'(VS * HT), 32'(VS * HT)}));
        check("valid_width", 64'({32'(va_min), 32'(va_max)}), 64'({32'(HA), 32'(HA)}));

        // en dropped mid-line, then re-raised.
        reset = 1; en = 0; cycle();
        reset = 0; en = 1;
        repeat (20) cycle();
        en = 0;
        repeat (5) cycle();
        check("en_drop_valid", 64'({valid1, valid3}), 64'(0));
        en = 1;
        repeat (3) cycle();
        check("en_rise_lat1", 64'({fs1, valid1, r1, g1, b1}), 64'({2'b11, mem_fn(8'd0)}));
        repeat (2) cycle();
        check("en_rise_lat3", 64'({fs3, valid3, r3, g3, b3}), 64'({2'b11, mem_fn(8'd0)}));
        check("en_rise_lat1_px2", 64'({valid1, r1, g1, b1}), 64'({1'b1, mem_fn(8'd2)}));

        // Randomised run: occasional reset, en drops and scale2x toggles.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            reset = (r < 3);
            if (en && r < 15) en = 0;
            else if (!en && r < 300) en = 1;
            if ($urandom_range(0, 39) == 0) scale2x = ~scale2x;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
